// File: rtl/lcd_nibble_driver.sv
// ---------------------------------------------------------------------------
// lcd_nibble_driver
//
// Drives the pins of a 4-bit HD44780-compatible character LCD from the
// nibble/strobe stream produced by the ALU's LCD instructions. One accepted
// write produces one complete nibble cycle on the pins:
// RS/D setup, E pulse, RS/D hold, then an idle gap. Busy is reported back
// to the ALU for the whole cycle.
//
// Optional feature (compile-time macro LCD_POWERUP_INIT_EN):
//   When defined, reset is followed by a power-up wait and the fixed
//   0x3,0x3,0x3,0x2 command nibble sequence that puts the panel into 4-bit
//   mode. User writes are ignored and busy stays high until it completes.
//   When undefined, the block is idle directly after reset and software is
//   responsible for panel initialisation.
//
// Ports:
//   Clock          in   system clock (rising edge active)
//   Reset          in   asynchronous active-low reset
//   iLCD_data[3:0] in   nibble to write
//   iLCD_rs        in   register select of the nibble (0 command, 1 data)
//   iLCD_writeEN   in   level-sensitive write request, sampled in IDLE only
//   oLCD_response  out  busy (init or transfer in progress)
//   oLCD_E         out  LCD enable
//   oLCD_RS        out  LCD register select
//   oLCD_RW        out  LCD read/write, always 0 (write only)
//   oLCD_D[3:0]    out  LCD data bus D7..D4
//
// All outputs come straight from flops; there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module lcd_nibble_driver #(
    parameter int unsigned SETUP_CYCLES     = 2,
    parameter int unsigned E_PULSE_CYCLES   = 12,
    parameter int unsigned HOLD_CYCLES      = 1,
    parameter int unsigned GAP_CYCLES       = 2000,
    parameter int unsigned POWERUP_CYCLES   = 750000,
    parameter int unsigned INIT_GAP1_CYCLES = 205000,
    parameter int unsigned INIT_GAP2_CYCLES = 5000,
    parameter int unsigned CNT_W            = 20
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] iLCD_data,
    input  logic       iLCD_rs,
    input  logic       iLCD_writeEN,
    output logic       oLCD_response,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic [3:0] oLCD_D
);

    // Counter reload values: a state lasting N cycles is entered with N-1
    // and advances on the cycle the counter reads 0.
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(E_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(GAP_CYCLES - 1);

`ifdef LCD_POWERUP_INIT_EN
    localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_IGAP1   = CNT_W'(INIT_GAP1_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_IGAP2   = CNT_W'(INIT_GAP2_CYCLES - 1);

    typedef enum logic [3:0] {
        S_POWERUP,
        S_INIT_SETUP,
        S_INIT_PULSE,
        S_INIT_HOLD,
        S_INIT_GAP,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_GAP
    } state_t;

    localparam state_t RESET_STATE = S_POWERUP;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_GAP
    } state_t;

    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       d_q, d_d;
    logic             rs_q, rs_d;
    logic             e_q, e_d;
    logic             resp_q, resp_d;
`ifdef LCD_POWERUP_INIT_EN
    logic [1:0]       idx_q, idx_d;     // which init nibble is in flight
    logic [CNT_W-1:0] init_gap_ld;
`endif

    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_dec;

    assign cnt_zero = (cnt_q == '0);
    assign cnt_dec  = cnt_q - 1'b1;

`ifdef LCD_POWERUP_INIT_EN
    // The first two init nibbles need the long datasheet waits; the last
    // two use the ordinary inter-nibble gap.
    always_comb begin
        init_gap_ld = LD_GAP;
        case (idx_q)
            2'd0:    init_gap_ld = LD_IGAP1;
            2'd1:    init_gap_ld = LD_IGAP2;
            default: init_gap_ld = LD_GAP;
        endcase
    end
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        rs_d    = rs_q;
`ifdef LCD_POWERUP_INIT_EN
        idx_d   = idx_q;
`endif

        case (state_q)
`ifdef LCD_POWERUP_INIT_EN
            // Reset clears the counter, so the power-up wait counts upwards
            // from 0; the reset cycle itself is the first counted cycle and
            // the first edge after release continues the count.
            S_POWERUP: begin
                if (cnt_q == LD_POWERUP) begin
                    state_d = S_INIT_SETUP;
                    cnt_d   = LD_SETUP;
                    d_d     = 4'h3;
                    rs_d    = 1'b0;
                    idx_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_INIT_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_INIT_PULSE;
                    cnt_d   = LD_PULSE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_INIT_PULSE: begin
                if (cnt_zero) begin
                    state_d = S_INIT_HOLD;
                    cnt_d   = LD_HOLD;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_INIT_HOLD: begin
                if (cnt_zero) begin
                    state_d = S_INIT_GAP;
                    cnt_d   = init_gap_ld;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_INIT_GAP: begin
                if (cnt_zero) begin
                    if (idx_q == 2'd3) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_INIT_SETUP;
                        cnt_d   = LD_SETUP;
                        idx_d   = idx_q + 2'd1;
                        // Fourth nibble is 0x2 (switch to 4-bit mode).
                        d_d     = (idx_q == 2'd2) ? 4'h2 : 4'h3;
                        rs_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_dec;
                end
            end
`endif
            S_IDLE: begin
                if (iLCD_writeEN) begin
                    state_d = S_SETUP;
                    cnt_d   = LD_SETUP;
                    d_d     = iLCD_data;
                    rs_d    = iLCD_rs;
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_PULSE;
                    cnt_d   = LD_PULSE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_PULSE: begin
                if (cnt_zero) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_HOLD: begin
                if (cnt_zero) begin
                    state_d = S_GAP;
                    cnt_d   = LD_GAP;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_GAP: begin
                if (cnt_zero) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            default: begin
                state_d = RESET_STATE;
                cnt_d   = '0;
            end
        endcase
    end

    // E and busy are registered copies of decodes of the *next* state so the
    // pins change on the same edge the state does.
    always_comb begin
        e_d    = (state_d == S_PULSE);
`ifdef LCD_POWERUP_INIT_EN
        e_d    = e_d | (state_d == S_INIT_PULSE);
`endif
        resp_d = (state_d != S_IDLE);
    end

    // -----------------------------------------------------------------------
    // State and output registers; reset aborts any E pulse immediately.
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            d_q     <= 4'h0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            resp_q  <= 1'b1;
`ifdef LCD_POWERUP_INIT_EN
            idx_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            rs_q    <= rs_d;
            e_q     <= e_d;
            resp_q  <= resp_d;
`ifdef LCD_POWERUP_INIT_EN
            idx_q   <= idx_d;
`endif
        end
    end

    assign oLCD_response = resp_q;
    assign oLCD_E        = e_q;
    assign oLCD_RS       = rs_q;
    assign oLCD_RW       = 1'b0;
    assign oLCD_D        = d_q;

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// ---------------------------------------------------------------------------
// Directed bench for lcd_nibble_driver with shortened timing
// (SETUP=2, PULSE=3, HOLD=1, GAP=4, POWERUP=10, INIT_GAP1=6, INIT_GAP2=5).
// Expected pin waveforms are written out by hand relative to the
// acceptance edge T:
//   T+1..T+2  setup  (busy, E=0)
//   T+3..T+5  pulse  (busy, E=1)
//   T+6       hold   (busy, E=0)
//   T+7..T+10 gap    (busy, E=0)
//   T+11      idle   (busy=0)
// Init sequence (only with LCD_POWERUP_INIT_EN): init nibbles start after
// release edges 10, 22, 33, 43; E is high after edges s+2..s+4; busy drops
// on edge 53.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_nibble_driver;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [3:0] iLCD_data;
    logic       iLCD_rs;
    logic       iLCD_writeEN;
    logic       oLCD_response;
    logic       oLCD_E;
    logic       oLCD_RS;
    logic       oLCD_RW;
    logic [3:0] oLCD_D;

    int checks = 0;
    int errors = 0;

    lcd_nibble_driver #(
        .SETUP_CYCLES     (2),
        .E_PULSE_CYCLES   (3),
        .HOLD_CYCLES      (1),
        .GAP_CYCLES       (4),
        .POWERUP_CYCLES   (10),
        .INIT_GAP1_CYCLES (6),
        .INIT_GAP2_CYCLES (5),
        .CNT_W            (20)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iLCD_data     (iLCD_data),
        .iLCD_rs       (iLCD_rs),
        .iLCD_writeEN  (iLCD_writeEN),
        .oLCD_response (oLCD_response),
        .oLCD_E        (oLCD_E),
        .oLCD_RS       (oLCD_RS),
        .oLCD_RW       (oLCD_RW),
        .oLCD_D        (oLCD_D)
    );

    always #5 Clock = ~Clock;

    // Advance past one rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_pins(input string tag);
        chk({tag, "_E"},    oLCD_E,        4'h0);
        chk({tag, "_RS"},   oLCD_RS,       4'h0);
        chk({tag, "_RW"},   oLCD_RW,       4'h0);
        chk({tag, "_D"},    oLCD_D,        4'h0);
        chk({tag, "_busy"}, oLCD_response, 4'h1);
    endtask

    // One complete nibble transfer starting with the acceptance edge.
    task automatic transfer(input string tag, input logic [3:0] data, input logic rs,
                            input logic hold, input logic mut_en, input logic [3:0] mut_data);
        iLCD_data    = data;
        iLCD_rs      = rs;
        iLCD_writeEN = 1'b1;
        tick();
        if (!hold) iLCD_writeEN = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (mut_en && k == 4) begin
                iLCD_data = mut_data;
                iLCD_rs   = ~rs;
            end
            chk({tag, "_busy"}, oLCD_response, 4'h1);
            chk({tag, "_E"},    oLCD_E,        (k >= 3 && k <= 5) ? 4'h1 : 4'h0);
            chk({tag, "_D"},    oLCD_D,        data);
            chk({tag, "_RS"},   oLCD_RS,       rs);
            chk({tag, "_RW"},   oLCD_RW,       4'h0);
            tick();
        end
        chk({tag, "_idle_busy"}, oLCD_response, 4'h0);
        chk({tag, "_idle_E"},    oLCD_E,        4'h0);
        $display("transfer %s data=%0h rs=%0d done", tag, data, rs);
    endtask

`ifdef LCD_POWERUP_INIT_EN
    // Call with Reset just released between edges.
    task automatic init_seq(input string tag);
        int   s [4];
        int   nib [4];
        logic exp_e;
        logic [3:0] exp_d;
        s   = '{10, 22, 33, 43};
        nib = '{3, 3, 3, 2};
        // A pending user write must be ignored during init.
        iLCD_data    = 4'h8;
        iLCD_rs      = 1'b1;
        iLCD_writeEN = 1'b1;
        for (int n = 1; n <= 53; n++) begin
            tick();
            if (n == 52) iLCD_writeEN = 1'b0;
            exp_e = 1'b0;
            exp_d = 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (n >= s[i] + 2 && n <= s[i] + 4) begin
                    exp_e = 1'b1;
                    exp_d = 4'(nib[i]);
                end
            end
            chk({tag, "_busy"}, oLCD_response, (n < 53) ? 4'h1 : 4'h0);
            chk({tag, "_E"},    oLCD_E,        exp_e);
            if (exp_e) begin
                chk({tag, "_D"},  oLCD_D,  exp_d);
                chk({tag, "_RS"}, oLCD_RS, 4'h0);
            end
        end
        $display("init sequence %s done", tag);
    endtask
`endif

    initial begin
        Reset        = 1'b0;
        iLCD_data    = 4'h0;
        iLCD_rs      = 1'b0;
        iLCD_writeEN = 1'b0;

        // Reset values.
        repeat (2) tick();
        chk_reset_pins("reset");
        $display("reset state checked");

        // Release reset between edges.
        Reset = 1'b1;
`ifdef LCD_POWERUP_INIT_EN
        init_seq("init");
`else
        // Write on the very first edge after release is accepted.
        transfer("first", 4'h8, 1'b0, 1'b0, 1'b0, 4'h0);
`endif

        // Idle with no request stays idle.
        tick();
        tick();
        chk("idle_busy", oLCD_response, 4'h0);
        chk("idle_E",    oLCD_E,        4'h0);
        $display("idle checked");

        // One-cycle strobe, data write.
        transfer("single", 4'hA, 1'b1, 1'b0, 1'b0, 4'h0);

        // Strobe held: back-to-back transfers with one idle cycle between.
        transfer("b2b0", 4'h4, 1'b0, 1'b1, 1'b0, 4'h0);
        transfer("b2b1", 4'h4, 1'b0, 1'b1, 1'b0, 4'h0);
        transfer("b2b2", 4'h4, 1'b0, 1'b0, 1'b0, 4'h0);

        // Inputs changed mid-pulse have no effect.
        tick();
        transfer("mut", 4'h5, 1'b1, 1'b0, 1'b1, 4'hF);

        // Reset in the middle of an E pulse.
        tick();
        iLCD_data    = 4'h6;
        iLCD_rs      = 1'b1;
        iLCD_writeEN = 1'b1;
        tick();
        iLCD_writeEN = 1'b0;
        tick();
        tick();
        chk("pre_abort_E", oLCD_E, 4'h1);
        #3;
        Reset = 1'b0;
        #1;
        chk_reset_pins("abort");
        tick();
        chk_reset_pins("abort_held");
        $display("reset during pulse checked");
        Reset = 1'b1;
`ifdef LCD_POWERUP_INIT_EN
        init_seq("reinit");
`else
        tick();
        chk("rel_busy", oLCD_response, 4'h0);
        chk("rel_E",    oLCD_E,        4'h0);
        chk("rel_D",    oLCD_D,        4'h0);
`endif

        // Normal operation after recovery.
        transfer("after", 4'h9, 1'b1, 1'b0, 1'b0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_nibble_driver.md
# lcd_nibble_driver

Physical-side driver for a 4-bit HD44780-compatible character LCD. It consumes the nibble stream and write strobe produced by the ALU's LCD instructions, and generates the LCD pin timing: RS/data setup, the E pulse, hold, and the inter-nibble gap. It reports busy back to the ALU, whose branch-while-busy loop polls that response. An optional power-on initialisation sequence forces the panel into 4-bit mode before the first user write is accepted.

## Interface
Parameters:
- SETUP_CYCLES, default 2: cycles RS/D are stable before E rises (≥40 ns at 50 MHz).
- E_PULSE_CYCLES, default 12: cycles E is held high (≥230 ns).
- HOLD_CYCLES, default 1: cycles RS/D are held after E falls.
- GAP_CYCLES, default 2000: cycles idle after each nibble (40 µs).
- POWERUP_CYCLES, default 750000: wait after reset before init (15 ms).
- INIT_GAP1_CYCLES, default 205000: gap after the first init nibble (4.1 ms).
- INIT_GAP2_CYCLES, default 5000: gap after the second init nibble (100 µs).
- CNT_W, default 20: delay counter width; must hold the largest delay parameter.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- iLCD_data  in  4  nibble to write.
- iLCD_rs  in  1  register select for this nibble (0 = command, 1 = data).
- iLCD_writeEN  in  1  write request, level-sensitive.
- oLCD_response  out  1  busy: 1 while init or a transfer is in progress.
- oLCD_E  out  1  LCD enable.
- oLCD_RS  out  1  LCD register select.
- oLCD_RW  out  1  LCD read/write, tied to 0.
- oLCD_D  out  4  LCD data bus D7..D4.

## Operation
- Reset asserted (Reset=0), at any time including mid-transfer:
  - State forced to POWERUP (macro defined) or IDLE (macro undefined).
  - Counter cleared.
  - oLCD_E=0, oLCD_RS=0, oLCD_RW=0, oLCD_D=0, oLCD_response=1.
  - Any partial E pulse is aborted immediately.
- States: POWERUP, INIT_SETUP, INIT_PULSE, INIT_HOLD, INIT_GAP, IDLE, SETUP, PULSE, HOLD, GAP.
- IDLE: oLCD_response=0, oLCD_E=0. If iLCD_writeEN=1:
  - Latch iLCD_data into oLCD_D and iLCD_rs into oLCD_RS.
  - Go to SETUP and set oLCD_response=1 (registered, visible the next cycle).
- SETUP → PULSE → HOLD → GAP, each lasting its parameter's cycle count:
  - oLCD_E=1 only in PULSE.
  - oLCD_D and oLCD_RS stay constant from latch through the end of GAP.
  - GAP then returns to IDLE.
- Inputs are ignored outside IDLE. Data changes during a transfer have no effect.
- If iLCD_writeEN is still 1 on the first IDLE cycle, a new transfer starts. The requester must drop the strobe or present the next nibble.
- Delay counter: loaded with the parameter value minus 1 on state entry, decrements to 0, then the state advances. A parameter value of 1 gives a single-cycle state. Parameter value 0 is illegal.
- oLCD_RW is constantly 0; the panel's busy flag is never read.

## Timing
- Acceptance cycle T (IDLE with iLCD_writeEN=1):
  - T+1: oLCD_response=1, D/RS valid.
  - T+1+SETUP_CYCLES: E rises.
  - E falls E_PULSE_CYCLES later.
  - oLCD_response falls at T+1+SETUP+PULSE+HOLD+GAP.
- Busy duration per nibble = SETUP_CYCLES+E_PULSE_CYCLES+HOLD_CYCLES+GAP_CYCLES exactly.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset release: the first active clock edge after Reset returns to 1 starts the POWERUP count (macro defined) or enters IDLE behaviour (macro undefined). oLCD_response falls on that edge in the undefined case.

## Configuration
- LCD_POWERUP_INIT_EN defined:
  - After reset, wait POWERUP_CYCLES.
  - Send RS=0 nibbles 0x3, 0x3, 0x3, 0x2. Each uses the SETUP/PULSE/HOLD timing.
  - Gaps after them are INIT_GAP1_CYCLES, INIT_GAP2_CYCLES, GAP_CYCLES and GAP_CYCLES respectively.
  - Then IDLE. oLCD_response stays 1 throughout and iLCD_writeEN is ignored.
- Undefined: POWERUP/INIT states are absent; the block is in IDLE directly after reset. Initialisation is left to software via normal writes.

## Test plan
Use SETUP=2, PULSE=3, HOLD=1, GAP=4, POWERUP=10, INIT_GAP1=6, INIT_GAP2=5 for simulation.
- Macro defined, reset release → E pulses 4 times carrying 0x3, 0x3, 0x3, 0x2 with RS=0. oLCD_response=1 until 10 + 4×6 + 6+5+4+4 cycles, then 0.
- Idle, one-cycle writeEN with data 0xA, rs=1 → response high next cycle. E high for exactly 3 cycles starting 2 cycles later with D=0xA, RS=1. Response low 10 cycles after acceptance+1.
- writeEN held high continuously with data 0x4 → back-to-back transfers. One IDLE cycle between each GAP end and the next acceptance.
- iLCD_data changed to 0xF mid-PULSE of a 0x5 write → oLCD_D stays 0x5 through GAP.
- Reset=0 during PULSE → oLCD_E=0, oLCD_D=0, response=1 in the same cycle without a clock edge. After release, sequence restarts per configuration.
- Macro undefined, reset release, write 0x8 on the first cycle → accepted immediately. No init pulses are observed.
